// File: rtl/i2c_master_burst.sv
// i2c_master_burst
// Single-master I2C controller. One accepted command produces
// START, address + R/W, then 0..MAX_BYTES data bytes (write or read), then STOP.
// An address or write-data NACK aborts the burst and goes straight to STOP.
//
// Ports
//   clk, rst_n         : clock, synchronous active-low reset
//   start              : request a transfer, taken only while free=1
//   add_reg, R_W       : slave address (MSB first) and direction (1=read)
//   byte_cnt           : burst length, clamped to MAX_BYTES
//   wr_data / rd_data  : byte k at [k*DATA_LEN +: DATA_LEN]
//   sda_in             : sampled SDA line level
//   scl                : push-pull clock
//   sda_oe             : 1 pulls SDA low, 0 releases it
//   free, done, nack   : idle flag, end-of-transfer pulse, NACK-abort flag
module i2c_master_burst #(
    parameter int FREQ_DIFF = 4,
    parameter int ADDR_LEN  = 7,
    parameter int DATA_LEN  = 8,
    parameter int MAX_BYTES = 4,
    parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ADDR_LEN-1:0]           add_reg,
    input  logic                          R_W,
    input  logic [CNT_W-1:0]              byte_cnt,
    input  logic [DATA_LEN*MAX_BYTES-1:0] wr_data,
    input  logic                          sda_in,
    output logic                          scl,
    output logic                          sda_oe,
    output logic [DATA_LEN*MAX_BYTES-1:0] rd_data,
    output logic                          free,
    output logic                          done,
    output logic                          nack
);
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RACK, S_STOP
    } state_t;

    localparam int QC_W  = (FREQ_DIFF > 1) ? $clog2(FREQ_DIFF) : 1;
    localparam int BIT_W = $clog2(((ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN) + 1);
    localparam logic [QC_W-1:0] QC_LAST = QC_W'(FREQ_DIFF - 1);

    state_t                        state_q, state_d;
    logic [QC_W-1:0]               qcnt_q;
    logic [1:0]                    quarter_q;
    logic [BIT_W-1:0]              bit_q;
    logic [CNT_W-1:0]              byte_q, nbytes_q;
    logic [ADDR_LEN:0]             addr_q;     // {address, R/W}, sent MSB first
    logic [DATA_LEN-1:0]           cur_q;      // write: outgoing byte; read: incoming byte
    logic [DATA_LEN*MAX_BYTES-1:0] wr_sh_q;    // remaining write bytes, next one in the low byte
    logic                          rw_q, ack_q, nack_q, done_q;

    logic tick, bit_end, sample_pt, accept, addr_last, data_last, byte_last, scl_mid;

    assign tick      = (qcnt_q == QC_LAST);
    assign bit_end   = tick && (quarter_q == 2'd3);
    assign sample_pt = tick && (quarter_q == 2'd1);
    assign accept    = (state_q == S_IDLE) && start;
    assign addr_last = (bit_q == BIT_W'(ADDR_LEN));
    assign data_last = (bit_q == BIT_W'(DATA_LEN - 1));
    assign byte_last = (byte_q == nbytes_q - CNT_W'(1));
    assign scl_mid   = quarter_q[0] ^ quarter_q[1];   // high during q1 and q2

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; ack_q holds the level sampled in q1 of the current bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_START;
            S_START: if (bit_end) state_d = S_ADDR;
            S_ADDR:  if (bit_end && addr_last) state_d = S_AACK;
            S_AACK:  if (bit_end) begin
                if (ack_q || nbytes_q == '0) state_d = S_STOP;
                else if (rw_q)               state_d = S_RDATA;
                else                         state_d = S_WDATA;
            end
            S_WDATA: if (bit_end && data_last) state_d = S_WACK;
            S_WACK:  if (bit_end) state_d = (ack_q || byte_last) ? S_STOP : S_WDATA;
            S_RDATA: if (bit_end && data_last) state_d = S_RACK;
            S_RACK:  if (bit_end) state_d = byte_last ? S_STOP : S_RDATA;
            S_STOP:  if (bit_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: line levels follow purely from state and quarter
    always_comb begin
        scl    = 1'b1;
        sda_oe = 1'b0;
        case (state_q)
            S_START: begin
                scl    = (quarter_q != 2'd3);
                sda_oe = quarter_q[1];            // SDA falls in q2 with SCL high
            end
            S_STOP: begin
                scl    = (quarter_q != 2'd0);
                sda_oe = ~quarter_q[1];           // SDA rises in q2 with SCL high
            end
            S_ADDR: begin
                scl    = scl_mid;
                sda_oe = ~addr_q[ADDR_LEN];
            end
            S_WDATA: begin
                scl    = scl_mid;
                sda_oe = ~cur_q[DATA_LEN-1];
            end
            S_AACK, S_WACK, S_RDATA: scl = scl_mid;
            S_RACK: begin
                scl    = scl_mid;
                sda_oe = ~byte_last;              // ACK all but the final read byte
            end
            default: ;
        endcase
    end

    assign free = (state_q == S_IDLE);
    assign done = done_q;
    assign nack = nack_q;

    // Bit timing and data path
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qcnt_q    <= '0;
            quarter_q <= 2'd0;
            bit_q     <= '0;
            byte_q    <= '0;
            nbytes_q  <= '0;
            addr_q    <= '0;
            cur_q     <= '0;
            wr_sh_q   <= '0;
            rw_q      <= 1'b0;
            ack_q     <= 1'b0;
            nack_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == S_STOP) && bit_end;
            if (accept) begin
                qcnt_q    <= '0;
                quarter_q <= 2'd0;
                bit_q     <= '0;
                byte_q    <= '0;
                nbytes_q  <= (byte_cnt > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : byte_cnt;
                addr_q    <= {add_reg, R_W};
                wr_sh_q   <= wr_data;
                rw_q      <= R_W;
                nack_q    <= 1'b0;
            end else if (state_q != S_IDLE) begin
                qcnt_q <= tick ? '0 : qcnt_q + QC_W'(1);
                if (tick) quarter_q <= quarter_q + 2'd1;
                if (sample_pt) begin
                    ack_q <= sda_in;
                    if (state_q == S_RDATA) cur_q <= {cur_q[DATA_LEN-2:0], sda_in};
                end
                if (bit_end) begin
                    case (state_q)
                        S_ADDR: begin
                            addr_q <= {addr_q[ADDR_LEN-1:0], 1'b0};
                            bit_q  <= addr_last ? '0 : bit_q + BIT_W'(1);
                        end
                        S_AACK: begin
                            bit_q  <= '0;
                            byte_q <= '0;
                            if (ack_q) nack_q <= 1'b1;
                            else if (!rw_q && nbytes_q != '0) begin
                                cur_q   <= wr_sh_q[DATA_LEN-1:0];
                                wr_sh_q <= wr_sh_q >> DATA_LEN;
                            end
                        end
                        S_WDATA: begin
                            cur_q <= {cur_q[DATA_LEN-2:0], 1'b0};
                            bit_q <= data_last ? '0 : bit_q + BIT_W'(1);
                        end
                        S_WACK: begin
                            if (ack_q) nack_q <= 1'b1;
                            else if (!byte_last) begin
                                byte_q  <= byte_q + CNT_W'(1);
                                cur_q   <= wr_sh_q[DATA_LEN-1:0];
                                wr_sh_q <= wr_sh_q >> DATA_LEN;
                            end
                        end
                        S_RDATA: bit_q <= data_last ? '0 : bit_q + BIT_W'(1);
                        S_RACK:  if (!byte_last) byte_q <= byte_q + CNT_W'(1);
                        default: ;
                    endcase
                end
            end
        end
    end

    // Read bytes: each slot updates only when its own byte completes,
    // so bytes beyond the current burst keep their earlier contents.
    generate
        for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_rd
            logic [DATA_LEN-1:0] rd_byte_q;
            always_ff @(posedge clk) begin
                if (!rst_n) rd_byte_q <= '0;
                else if (state_q == S_RDATA && bit_end && data_last && byte_q == CNT_W'(gi))
                    rd_byte_q <= cur_q;
            end
            assign rd_data[gi*DATA_LEN +: DATA_LEN] = rd_byte_q;
        end
    endgenerate
endmodule

// File: tb/tb_i2c_master_burst.sv
module tb_i2c_master_burst;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  add_reg = '0;
    logic        R_W = 1'b0;
    logic [2:0]  byte_cnt = '0;
    logic [31:0] wr_data = '0;
    logic        scl, sda_oe, free, done, nack;
    logic [31:0] rd_data;
    logic        slave_drv = 1'b1;
    logic        sda_line;

    assign sda_line = ~sda_oe & slave_drv;

    i2c_master_burst #(.FREQ_DIFF(4), .ADDR_LEN(7), .DATA_LEN(8), .MAX_BYTES(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .add_reg(add_reg), .R_W(R_W),
        .byte_cnt(byte_cnt), .wr_data(wr_data), .sda_in(sda_line), .scl(scl),
        .sda_oe(sda_oe), .rd_data(rd_data), .free(free), .done(done), .nack(nack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        string       name;
        int          n;
        logic [63:0] bits;
        logic [31:0] rd;
        logic        nk;
        int          cycles;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Slave model / bus monitor: START/STOP detection, bit capture on SCL rise,
    // slave drive updated on SCL fall from a per-transfer plan (1 = release).
    int          plan_n = 0;
    logic [63:0] plan_bits = '0;
    logic [63:0] cap = '0;
    int          cap_n = 0;
    int          slave_p = 0;
    bit          active = 0;
    bit          stop_seen = 0;
    logic        scl_prev = 1'b1, sda_prev = 1'b1;

    always @(scl or sda_line) begin
        if (scl === 1'b1 && scl_prev === 1'b1 && sda_prev === 1'b1 && sda_line === 1'b0) begin
            active = 1; slave_p = -1; slave_drv = 1'b1; cap = '0; cap_n = 0; stop_seen = 0;
        end else if (scl === 1'b1 && scl_prev === 1'b1 && sda_prev === 1'b0 && sda_line === 1'b1) begin
            // the SCL rise inside STOP was captured as a bit; drop it
            if (active && cap_n > 0) begin cap = cap >> 1; cap_n--; end
            active = 0; stop_seen = 1;
        end else if (scl_prev === 1'b0 && scl === 1'b1 && active) begin
            cap = {cap[62:0], sda_line}; cap_n++;
        end else if (scl_prev === 1'b1 && scl === 1'b0 && active) begin
            slave_p++;
            slave_drv = (slave_p < plan_n) ? plan_bits[plan_n-1-slave_p] : 1'b1;
        end
        scl_prev = scl;
        sda_prev = sda_line;
    end

    // Scoreboard monitor
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (prev_done) chk("done_pulse_width", {63'd0, done}, 64'd0);
        if (rst_n && done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("xfer %s bits=%0d seq=%0h cycles=%0d nack=%b rd=%h",
                         e.name, cap_n, cap, cyc - acc_cyc, nack, rd_data);
                chk({e.name, "_nbits"}, 64'(cap_n), 64'(e.n));
                chk({e.name, "_sda"}, cap, e.bits);
                chk({e.name, "_stop"}, {63'd0, stop_seen}, 64'd1);
                chk({e.name, "_rd"}, {32'd0, rd_data}, {32'd0, e.rd});
                chk({e.name, "_nack"}, {63'd0, nack}, {63'd0, e.nk});
                chk({e.name, "_cycles"}, 64'(cyc - acc_cyc), 64'(e.cycles));
                chk({e.name, "_free"}, {63'd0, free}, 64'd1);
            end
        end
        prev_done = done;
    end

    task automatic xfer(input string nm, input logic [6:0] a, input logic rw, input logic [2:0] cnt,
                        input logic [31:0] wd, input int pn, input logic [63:0] pb,
                        input int en, input logic [63:0] eb, input logic [31:0] erd,
                        input logic enk, input int ecyc, input bit pulse);
        exp_t e;
        int k;
        plan_n = pn; plan_bits = pb;
        e.name = nm; e.n = en; e.bits = eb; e.rd = erd; e.nk = enk; e.cycles = ecyc;
        sb_q.push_back(e);
        @(negedge clk);
        add_reg = a; R_W = rw; byte_cnt = cnt; wr_data = wd; start = 1'b1;
        @(negedge clk);
        start = 1'b0; acc_cyc = cyc;
        add_reg = ~a; R_W = ~rw; wr_data = ~wd;   // latched copies must be used
        chk({nm, "_busy"}, {63'd0, free}, 64'd0);
        chk({nm, "_nack_clr"}, {63'd0, nack}, 64'd0);
        if (pulse) begin
            repeat (50) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk({nm, "_ignore_start"}, {63'd0, free}, 64'd0);
        end
        k = 0;
        while (!free && k < 3000) begin @(negedge clk); k++; end
        if (!free) chk({nm, "_timeout"}, 64'd1, 64'd0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int dc;
        repeat (3) @(negedge clk);
        chk("rst_scl", {63'd0, scl}, 64'd1);
        chk("rst_sda_oe", {63'd0, sda_oe}, 64'd0);
        chk("rst_free", {63'd0, free}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_nack", {63'd0, nack}, 64'd0);
        chk("rst_rd", {32'd0, rd_data}, 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        xfer("write2", 7'h56, 1'b0, 3'd2, 32'h0000EFAB,
             27, {8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0},
             27, {7'h56, 1'b0, 1'b0, 8'hAB, 1'b0, 8'hEF, 1'b0},
             32'h00000000, 1'b0, 464, 0);
        xfer("read3", 7'h50, 1'b1, 3'd3, 32'h0,
             36, {8'hFF, 1'b0, 8'h12, 1'b1, 8'h34, 1'b1, 8'h56, 1'b1},
             36, {7'h50, 1'b1, 1'b0, 8'h12, 1'b0, 8'h34, 1'b0, 8'h56, 1'b1},
             32'h00563412, 1'b0, 608, 0);
        xfer("read1", 7'h50, 1'b1, 3'd1, 32'h0,
             18, {8'hFF, 1'b0, 8'h9E, 1'b1},
             18, {7'h50, 1'b1, 1'b0, 8'h9E, 1'b1},
             32'h0056349E, 1'b0, 320, 0);
        xfer("addr_nack", 7'h3C, 1'b0, 3'd4, 32'h11223344,
             9, {8'hFF, 1'b1},
             9, {7'h3C, 1'b0, 1'b1},
             32'h0056349E, 1'b1, 176, 0);
        xfer("wr_nack_b1", 7'h21, 1'b0, 3'd3, 32'h00332211,
             27, {8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b1},
             27, {7'h21, 1'b0, 1'b0, 8'h11, 1'b0, 8'h22, 1'b1},
             32'h0056349E, 1'b1, 464, 0);
        xfer("clamp7", 7'h0F, 1'b0, 3'd7, 32'hC3A55A3C,
             45, {8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0},
             45, {7'h0F, 1'b0, 1'b0, 8'h3C, 1'b0, 8'h5A, 1'b0, 8'hA5, 1'b0, 8'hC3, 1'b0},
             32'h0056349E, 1'b0, 752, 0);

        // Reset in the middle of the address phase
        plan_n = 0;
        @(negedge clk);
        add_reg = 7'h05; R_W = 1'b0; byte_cnt = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        dc = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_scl", {63'd0, scl}, 64'd1);
        chk("midrst_sda_oe", {63'd0, sda_oe}, 64'd0);
        chk("midrst_free", {63'd0, free}, 64'd1);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_rd", {32'd0, rd_data}, 64'd0);
        rst_n = 1'b1;
        repeat (600) @(negedge clk);
        chk("midrst_no_done", 64'(done_cnt), 64'(dc));
        $display("xfer reset_mid_addr done_pulses=%0d", done_cnt - dc);

        xfer("probe_pulse", 7'h48, 1'b0, 3'd0, 32'h0,
             9, {8'hFF, 1'b0},
             9, {7'h48, 1'b0, 1'b0},
             32'h00000000, 1'b0, 176, 1);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
